// File: rtl/vga_pkg.sv
// Shared constants for the bouncing-box renderer: display defaults, palette,
// background colour and the motion FSM encoding.
package vga_pkg;
  localparam int HDISPLAY_DEF = 640;
  localparam int VDISPLAY_DEF = 480;

  localparam logic [11:0] BG_COLOUR = 12'h113;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_UPD_X = 2'd1,
    ST_UPD_Y = 2'd2
  } motion_state_t;

  // 4-entry palette, {R,G,B} nibbles
  function automatic logic [11:0] palette(input logic [1:0] idx);
    case (idx)
      2'd0:    palette = 12'hF80;
      2'd1:    palette = 12'h0F0;
      2'd2:    palette = 12'h0FF;
      default: palette = 12'hF0F;
    endcase
  endfunction
endpackage

// File: rtl/box_motion.sv
// Box position/direction/colour state, advanced once per frame boundary:
// X in one cycle, Y and colour in the next.
module box_motion
  import vga_pkg::*;
#(
  parameter int HDISPLAY = HDISPLAY_DEF,
  parameter int VDISPLAY = VDISPLAY_DEF,
  parameter int BOX      = 32,
  parameter int STEP     = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       frame,
  input  logic       pause,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [1:0] colour
);
  localparam logic [10:0] XMAX   = 11'(HDISPLAY - BOX);
  localparam logic [10:0] YMAX   = 11'(VDISPLAY - BOX);
  localparam logic [10:0] STEP11 = 11'(STEP);

  motion_state_t state;
  logic          dx, dy, bounce_x;
  logic [10:0]   x_ext, y_ext;
  logic          x_hit, y_hit;

  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};
  // dx/dy: 1 = right/down
  assign x_hit = dx ? (x_ext + STEP11 >= XMAX) : (x_ext <= STEP11);
  assign y_hit = dy ? (y_ext + STEP11 >= YMAX) : (y_ext <= STEP11);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_WAIT;
      x        <= '0;
      y        <= '0;
      dx       <= 1'b1;
      dy       <= 1'b1;
      colour   <= '0;
      bounce_x <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: if (frame && !pause) state <= ST_UPD_X;
        ST_UPD_X: begin
          state    <= ST_UPD_Y;
          bounce_x <= x_hit;
          if (x_hit) begin
            x  <= dx ? XMAX[9:0] : '0;
            dx <= ~dx;
          end else begin
            x <= dx ? x + STEP11[9:0] : x - STEP11[9:0];
          end
        end
        ST_UPD_Y: begin
          state <= ST_WAIT;
          if (y_hit) begin
            y  <= dy ? YMAX[9:0] : '0;
            dy <= ~dy;
          end else begin
            y <= dy ? y + STEP11[9:0] : y - STEP11[9:0];
          end
          // a corner hit still only advances the colour once
          colour <= colour + {1'b0, bounce_x | y_hit};
        end
        default: state <= ST_WAIT;
      endcase
    end
  end
endmodule

// File: rtl/vga_bounce_render.sv
// Bouncing-box pixel renderer: 2-stage pixel pipeline behind an external sync
// generator, with sync delayed to line up with the colour output.
module vga_bounce_render
  import vga_pkg::*;
#(
  parameter int HDISPLAY = HDISPLAY_DEF,
  parameter int VDISPLAY = VDISPLAY_DEF,
  parameter int BOX      = 32,
  parameter int STEP     = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] HCOUNT,
  input  logic [9:0] VCOUNT,
  input  logic       HS_IN,
  input  logic       VS_IN,
  input  logic       PAUSE,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       FRAME_TICK
);
  localparam logic [10:0] H11   = 11'(HDISPLAY);
  localparam logic [10:0] V11   = 11'(VDISPLAY);
  localparam logic [10:0] BOXM1 = 11'(BOX - 1);

  logic [9:0]  x, y;
  logic [1:0]  colour;
  logic [10:0] h_ext, v_ext, x_ext, y_ext;
  logic        frame;
  logic        act_q, box_q;
  logic [11:0] rgb_q;
  logic [1:0]  hs_pipe, vs_pipe;

  assign h_ext = {1'b0, HCOUNT};
  assign v_ext = {1'b0, VCOUNT};
  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};
  // first cycle of vertical blanking: position updates land here, off-screen
  assign frame = (v_ext == V11) && (HCOUNT == '0);

  box_motion #(
    .HDISPLAY(HDISPLAY), .VDISPLAY(VDISPLAY), .BOX(BOX), .STEP(STEP)
  ) u_motion (
    .CLK   (CLK),
    .RST   (RST),
    .frame (frame),
    .pause (PAUSE),
    .x     (x),
    .y     (y),
    .colour(colour)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      act_q      <= 1'b0;
      box_q      <= 1'b0;
      rgb_q      <= '0;
      hs_pipe    <= '0;
      vs_pipe    <= '0;
      FRAME_TICK <= 1'b0;
    end else begin
      FRAME_TICK <= frame;
      act_q      <= (h_ext < H11) && (v_ext < V11);
      box_q      <= (h_ext >= x_ext) && (h_ext <= x_ext + BOXM1) &&
                    (v_ext >= y_ext) && (v_ext <= y_ext + BOXM1);
      rgb_q      <= !act_q ? 12'h000 : (box_q ? palette(colour) : BG_COLOUR);
      hs_pipe    <= {hs_pipe[0], HS_IN};
      vs_pipe    <= {vs_pipe[0], VS_IN};
    end
  end

  assign VGA_R  = rgb_q[11:8];
  assign VGA_G  = rgb_q[7:4];
  assign VGA_B  = rgb_q[3:0];
  assign VGA_HS = hs_pipe[1];
  assign VGA_VS = vs_pipe[1];
endmodule
